// File: rtl/h2c_traffic_chk.sv
// h2c_traffic_chk: H2C-side sink and checker for the QDMA traffic test path.
// Consumes host-to-card AXI-stream packets in the traffic-gen frame format,
// checks header, payload, trailer, length and queue rotation, and keeps
// packet/byte/error/cycle counts for the host status registers.
// Ports:
//   axi_aclk, axi_aresetn        clock, synchronous active-low reset
//   control_reg                  [1] start (rising edge), [2] random backpressure
//   txr_size, num_pkt            expected packet size in bytes, packets per run
//   qid, num_queue               base queue id and round-robin queue count
//   h2c_valid/data/last/qid      stream input; h2c_ready stream ready
//   pkt_count, err_count         completed packets, packets with any error
//   byte_count, cycle_count      sum of txr_size, cycles first beat -> final last
//   err_flags                    sticky {qid, length, trailer, payload, hdr}
//   done                         high in DONE state
module h2c_traffic_chk #(
  parameter int          DATA_W  = 512,
  parameter logic [47:0] SRC_MAC = 48'h665544332211,
  parameter logic [15:0] ETYPE   = 16'h2121,
  parameter logic [31:0] TRAILER = 32'h0a212121
) (
  input  logic              axi_aclk,
  input  logic              axi_aresetn,
  input  logic [31:0]       control_reg,
  input  logic [15:0]       txr_size,
  input  logic [31:0]       num_pkt,
  input  logic [10:0]       qid,
  input  logic [10:0]       num_queue,
  input  logic              h2c_valid,
  input  logic [DATA_W-1:0] h2c_data,
  input  logic              h2c_last,
  input  logic [10:0]       h2c_qid,
  output logic              h2c_ready,
  output logic [31:0]       pkt_count,
  output logic [31:0]       err_count,
  output logic [31:0]       byte_count,
  output logic [31:0]       cycle_count,
  output logic [4:0]        err_flags,
  output logic              done
);
  localparam int BYTES = DATA_W / 8;
  localparam int BW    = 17;

  typedef enum logic [1:0] { S_IDLE, S_ACTIVE, S_DONE } state_t;

  state_t          state_q, state_d;
  logic            start_r_q, start_r_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [15:0]     size_q, size_d;
  logic [31:0]     npkt_q, npkt_d;
  logic [10:0]     qbase_q, qbase_d;
  logic [10:0]     nq_q, nq_d;
  logic [BW-1:0]   beats_exp_q, beats_exp_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [1:0]      mac_idx_q, mac_idx_d;
  logic [10:0]     exp_qid_q, exp_qid_d;
  logic [4:0]      pkt_err_q, pkt_err_d;
  logic            end_q, end_d;
  logic [4:0]      end_err_q, end_err_d;
  logic [31:0]     pkts_q, pkts_d;
  logic            run_q, run_d;
  logic [31:0]     pkt_count_q, pkt_count_d;
  logic [31:0]     err_count_q, err_count_d;
  logic [31:0]     byte_count_q, byte_count_d;
  logic [31:0]     cycle_count_q, cycle_count_d;
  logic [4:0]      err_flags_q, err_flags_d;

  logic            start_edge, acc, first_b, last_b, in_rng;
  logic [DATA_W-1:0] exp_beat, diff, pay;
  logic [4:0]      beat_err;
  logic [BW-1:0]   beats_calc;
  logic            unused_ctrl;

  assign unused_ctrl = ^{control_reg[31:3], control_reg[0]};
  assign start_edge  = control_reg[1] & ~start_r_q;
  assign h2c_ready   = (state_q == S_ACTIVE) ? (control_reg[2] ? lfsr_q[0] : 1'b1)
                                             : (state_q == S_DONE);
  assign acc         = h2c_valid & h2c_ready & (state_q == S_ACTIVE);
  assign beats_calc  = ({1'b0, txr_size} + BW'(BYTES - 1)) >> $clog2(BYTES);

  // Per-beat check against the expected frame contents
  always_comb begin
    first_b  = (beat_q == '0);
    last_b   = (beat_q == beats_exp_q - BW'(1));
    in_rng   = (beat_q < beats_exp_q);
    exp_beat = {BYTES{8'h41}};
    if (first_b) begin
      exp_beat[15:0]   = ETYPE;
      exp_beat[63:16]  = SRC_MAC;
      exp_beat[111:64] = 48'h1 + {46'b0, mac_idx_q};
    end
    if (last_b) exp_beat[DATA_W-1 -: 32] = TRAILER;
    diff = h2c_data ^ exp_beat;
    pay  = diff;
    if (first_b) pay[111:0] = '0;
    if (last_b)  pay[DATA_W-1 -: 32] = '0;
    beat_err    = '0;
    beat_err[0] = in_rng & first_b & (|diff[111:0]);
    beat_err[1] = in_rng & (|pay);
    beat_err[2] = in_rng & last_b & (|diff[DATA_W-1 -: 32]);
    beat_err[4] = first_b & (h2c_qid != exp_qid_q);
  end

  always_comb begin
    state_d       = state_q;
    start_r_d     = control_reg[1];
    lfsr_d        = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    size_d        = size_q;
    npkt_d        = npkt_q;
    qbase_d       = qbase_q;
    nq_d          = nq_q;
    beats_exp_d   = beats_exp_q;
    beat_d        = beat_q;
    mac_idx_d     = mac_idx_q;
    exp_qid_d     = exp_qid_q;
    pkt_err_d     = pkt_err_q;
    end_d         = 1'b0;
    end_err_d     = '0;
    pkts_d        = pkts_q;
    run_d         = run_q;
    pkt_count_d   = pkt_count_q;
    err_count_d   = err_count_q;
    byte_count_d  = byte_count_q;
    cycle_count_d = cycle_count_q;
    err_flags_d   = err_flags_q;

    // Packet results land one cycle after the last beat, in any state
    if (end_q) begin
      pkt_count_d  = pkt_count_q + 32'd1;
      byte_count_d = byte_count_q + {16'b0, size_q};
      if (|end_err_q) err_count_d = err_count_q + 32'd1;
      err_flags_d  = err_flags_q | end_err_q;
    end

    if ((state_q == S_ACTIVE) && (run_q || acc)) begin
      cycle_count_d = cycle_count_q + 32'd1;
      run_d         = 1'b1;
    end

    if (acc) begin
      if (h2c_last) begin
        end_d     = 1'b1;
        end_err_d = pkt_err_q | beat_err;
        if (beat_q + BW'(1) < beats_exp_q) end_err_d[3] = 1'b1;
        beat_d    = '0;
        pkt_err_d = '0;
        mac_idx_d = mac_idx_q + 2'd1;
        exp_qid_d = (exp_qid_q == qbase_q + nq_q - 11'd1) ? qbase_q : exp_qid_q + 11'd1;
        pkts_d    = pkts_q + 32'd1;
        if (pkts_q + 32'd1 == npkt_q) state_d = S_DONE;
      end else begin
        // Missing last at the final expected beat; excess beats are skipped
        pkt_err_d = pkt_err_q | beat_err;
        if (last_b) pkt_err_d[3] = 1'b1;
        if (in_rng) beat_d = beat_q + BW'(1);
      end
    end

    if (start_edge) begin
      state_d       = (num_pkt == '0) ? S_DONE : S_ACTIVE;
      size_d        = txr_size;
      npkt_d        = num_pkt;
      qbase_d       = qid;
      nq_d          = num_queue;
      beats_exp_d   = beats_calc;
      beat_d        = '0;
      mac_idx_d     = '0;
      exp_qid_d     = qid;
      pkt_err_d     = '0;
      end_d         = 1'b0;
      end_err_d     = '0;
      pkts_d        = '0;
      run_d         = 1'b0;
      pkt_count_d   = '0;
      err_count_d   = '0;
      byte_count_d  = '0;
      cycle_count_d = '0;
      err_flags_d   = '0;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      state_q       <= S_IDLE;
      start_r_q     <= 1'b0;
      lfsr_q        <= 16'hACE1;
      size_q        <= '0;
      npkt_q        <= '0;
      qbase_q       <= '0;
      nq_q          <= '0;
      beats_exp_q   <= '0;
      beat_q        <= '0;
      mac_idx_q     <= '0;
      exp_qid_q     <= '0;
      pkt_err_q     <= '0;
      end_q         <= 1'b0;
      end_err_q     <= '0;
      pkts_q        <= '0;
      run_q         <= 1'b0;
      pkt_count_q   <= '0;
      err_count_q   <= '0;
      byte_count_q  <= '0;
      cycle_count_q <= '0;
      err_flags_q   <= '0;
    end else begin
      state_q       <= state_d;
      start_r_q     <= start_r_d;
      lfsr_q        <= lfsr_d;
      size_q        <= size_d;
      npkt_q        <= npkt_d;
      qbase_q       <= qbase_d;
      nq_q          <= nq_d;
      beats_exp_q   <= beats_exp_d;
      beat_q        <= beat_d;
      mac_idx_q     <= mac_idx_d;
      exp_qid_q     <= exp_qid_d;
      pkt_err_q     <= pkt_err_d;
      end_q         <= end_d;
      end_err_q     <= end_err_d;
      pkts_q        <= pkts_d;
      run_q         <= run_d;
      pkt_count_q   <= pkt_count_d;
      err_count_q   <= err_count_d;
      byte_count_q  <= byte_count_d;
      cycle_count_q <= cycle_count_d;
      err_flags_q   <= err_flags_d;
    end
  end

  assign pkt_count   = pkt_count_q;
  assign err_count   = err_count_q;
  assign byte_count  = byte_count_q;
  assign cycle_count = cycle_count_q;
  assign err_flags   = err_flags_q;
  assign done        = (state_q == S_DONE);
endmodule
